// File: rtl/poly_host_seq_pkg.sv
// Shared definitions for the polynomial host sequencer: core mode codes,
// word geometry and the sequencer state encoding.
package poly_host_seq_pkg;

   localparam int unsigned COEF_W     = 12;
   localparam int unsigned WORD_W     = 4 * COEF_W;
   localparam int unsigned POLY_WORDS = 32;
   localparam int unsigned IDX_W      = $clog2(POLY_WORDS);

   typedef enum logic [1:0] {
      M_NTT     = 2'd0,
      M_INTT    = 2'd1,
      M_DATAIN  = 2'd2,
      M_DATAOUT = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LOAD_FIN,
      S_EXEC,
      S_WAIT,
      S_UNL_LAT,
      S_UNLOAD
   } state_e;

endpackage

// File: rtl/poly_seq_cnt.sv
// Word index counter shared by load and unload: start clears, enable steps,
// tc flags the last word of a polynomial.
module poly_seq_cnt
   import poly_host_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             en,
   output logic [IDX_W-1:0] cnt,
   output logic             tc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + IDX_W'(1);
      end
   end

   assign tc = (cnt == IDX_W'(POLY_WORDS - 1));

endmodule

// File: rtl/poly_host_seq.sv
// Host-side sequencer for the polynomial core: accepts one command at a time,
// streams load words from source memory, runs NTT/INTT with timeout, unloads.
module poly_host_seq
   import poly_host_seq_pkg::*;
#(
   parameter int unsigned WID      = WORD_W / 4,
   parameter int unsigned DOUT_LAT = 2,
   parameter int unsigned TMO      = 4096
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   input  logic [1:0]           cmd_op,
   output logic                 cmd_ready,
   output logic [IDX_W-1:0]     src_addr,
   input  logic [4*WID-1:0]     src_data,
   output logic [1:0]           core_mode,
   output logic                 core_run,
   output logic [4*WID-1:0]     core_data_in,
   output logic [IDX_W-1:0]     core_data_in_add,
   output logic                 core_data_in_done,
   input  logic                 core_done,
   input  logic [4*WID-1:0]     core_data_out,
   output logic                 out_valid,
   output logic [4*WID-1:0]     out_data,
   output logic [IDX_W-1:0]     out_idx,
   output logic                 err,
   input  logic                 err_clr
);

   localparam int unsigned LW = (DOUT_LAT > 1) ? $clog2(DOUT_LAT) : 1;
   localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;

   state_e           state;
   logic             ld_vld;
   logic [LW-1:0]    lat_cnt;
   logic [TW-1:0]    tmo_cnt;
   logic             cnt_start;
   logic             cnt_en;
   logic [IDX_W-1:0] cnt;
   logic             cnt_tc;

   assign cmd_ready = (state == S_IDLE);
   assign cnt_start = (state == S_IDLE) && cmd_valid;
   assign cnt_en    = (state == S_LOAD) || (state == S_UNLOAD);

   poly_seq_cnt u_cnt (
      .clk   (clk),
      .rst   (rst),
      .start (cnt_start),
      .en    (cnt_en),
      .cnt   (cnt),
      .tc    (cnt_tc)
   );

   // Memory read has one cycle of latency, so the data path is gated by a
   // flag that trails the address by one cycle, matching core_data_in_add.
   assign src_addr     = (state == S_LOAD) ? cnt : '0;
   assign core_data_in = ld_vld ? src_data : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= S_IDLE;
         core_mode         <= '0;
         core_run          <= 1'b0;
         ld_vld            <= 1'b0;
         core_data_in_add  <= '0;
         core_data_in_done <= 1'b0;
         out_valid         <= 1'b0;
         out_data          <= '0;
         out_idx           <= '0;
         lat_cnt           <= '0;
         tmo_cnt           <= '0;
         err               <= 1'b0;
      end else begin
         core_run  <= 1'b0;
         out_valid <= 1'b0;
         // A timeout in the same cycle overrides this clear below.
         if (err_clr) err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  core_mode <= cmd_op;
                  core_run  <= 1'b1;
                  lat_cnt   <= '0;
                  tmo_cnt   <= '0;
                  case (cmd_op)
                     M_DATAIN:  state <= S_LOAD;
                     M_DATAOUT: state <= S_UNL_LAT;
                     default:   state <= S_EXEC;
                  endcase
               end
            end
            S_LOAD: begin
               ld_vld           <= 1'b1;
               core_data_in_add <= cnt;
               if (cnt_tc) state <= S_LOAD_FIN;
            end
            // Two cycles: the trailing word 31 beat, then the done pulse.
            S_LOAD_FIN: begin
               if (!core_data_in_done) begin
                  ld_vld            <= 1'b0;
                  core_data_in_add  <= '0;
                  core_data_in_done <= 1'b1;
               end else begin
                  core_data_in_done <= 1'b0;
                  core_mode         <= '0;
                  state             <= S_IDLE;
               end
            end
            S_EXEC: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  core_mode <= '0;
                  state     <= S_IDLE;
               end else if (tmo_cnt == TW'(TMO - 1)) begin
                  err       <= 1'b1;
                  core_mode <= '0;
                  state     <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            S_UNL_LAT: begin
               if (lat_cnt == LW'(DOUT_LAT - 1)) state <= S_UNLOAD;
               else lat_cnt <= lat_cnt + LW'(1);
            end
            S_UNLOAD: begin
               out_valid <= 1'b1;
               out_data  <= core_data_out;
               out_idx   <= cnt;
               if (cnt_tc) begin
                  core_mode <= '0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_poly_host_seq.sv
// Scoreboard bench for poly_host_seq: expected load/done/unload events are
// queued at issue time and checked by a negedge monitor as the DUT emits them.
module tb_poly_host_seq;

   localparam int DLAT = 2;
   localparam logic [47:0] PAT = 48'h5A5A_0000_0000;

   typedef struct {
      int          off;
      logic [4:0]  idx;
      logic [47:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_op = 2'd0;
   logic        cmd_ready;
   logic [4:0]  src_addr;
   logic [47:0] src_data = '0;
   logic [1:0]  core_mode;
   logic        core_run;
   logic [47:0] core_data_in;
   logic [4:0]  core_data_in_add;
   logic        core_data_in_done;
   logic        core_done = 1'b0;
   logic [47:0] core_data_out = '0;
   logic        out_valid;
   logic [47:0] out_data;
   logic [4:0]  out_idx;
   logic        err;
   logic        err_clr = 1'b0;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   run_cyc = -1000;
   int   ubase = -1000;
   exp_t ld_q[$];
   exp_t out_q[$];
   int   done_q[$];

   poly_host_seq #(.WID(12), .DOUT_LAT(DLAT), .TMO(4096)) dut (
      .clk               (clk),
      .rst               (rst),
      .cmd_valid         (cmd_valid),
      .cmd_op            (cmd_op),
      .cmd_ready         (cmd_ready),
      .src_addr          (src_addr),
      .src_data          (src_data),
      .core_mode         (core_mode),
      .core_run          (core_run),
      .core_data_in      (core_data_in),
      .core_data_in_add  (core_data_in_add),
      .core_data_in_done (core_data_in_done),
      .core_done         (core_done),
      .core_data_out     (core_data_out),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_idx           (out_idx),
      .err               (err),
      .err_clr           (err_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Source ROM, word k = 3k, one-cycle read latency.
   always @(posedge clk) src_data <= 48'(src_addr) * 48'd3;

   // Core unload model: word k valid DLAT+k cycles after core_run.
   always @(negedge clk) begin
      int k;
      if (core_run && core_mode == 2'd3) ubase = cyc;
      k = cyc - ubase - DLAT;
      core_data_out = (k >= 0 && k < 32) ? PAT + 48'(k) : '0;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a word or pulse.
   always @(negedge clk) begin
      exp_t e;
      int   d;
      if (!rst) begin
         if (core_run) run_cyc = cyc;
         if (ld_q.size() > 0 && (cyc - run_cyc) == ld_q[0].off) begin
            e = ld_q.pop_front();
            chk("load_add", 64'(core_data_in_add), 64'(e.idx));
            chk("load_data", 64'(core_data_in), 64'(e.data));
         end
         if (core_data_in_done) begin
            if (done_q.size() == 0) chk("done_unexpected", 64'(core_data_in_done), 64'd0);
            else begin
               d = done_q.pop_front();
               chk("done_offset", 64'(cyc - run_cyc), 64'(d));
            end
         end
         if (out_valid) begin
            if (out_q.size() == 0) chk("out_unexpected", 64'(out_valid), 64'd0);
            else begin
               e = out_q.pop_front();
               chk("out_offset", 64'(cyc - run_cyc), 64'(e.off));
               chk("out_idx", 64'(out_idx), 64'(e.idx));
               chk("out_data", 64'(out_data), 64'(e.data));
            end
         end
      end
   end

   task automatic push_load();
      exp_t e;
      for (int k = 0; k < 32; k++) begin
         e.off = k + 1;
         e.idx = 5'(k);
         e.data = 48'(k * 3);
         ld_q.push_back(e);
      end
      done_q.push_back(33);
   endtask

   task automatic push_unload();
      exp_t e;
      for (int k = 0; k < 32; k++) begin
         e.off = DLAT + 1 + k;
         e.idx = 5'(k);
         e.data = PAT + 48'(k);
         out_q.push_back(e);
      end
   endtask

   task automatic wait_run(input int lim, output int at);
      at = -1;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (core_run) begin
            at = cyc;
            break;
         end
      end
      chk("run_seen", 64'(at >= 0), 64'd1);
   endtask

   task automatic wait_drain(input int lim);
      for (int i = 0; i < lim && (ld_q.size() + done_q.size() + out_q.size()) > 0; i++)
         @(negedge clk);
      chk("drain", 64'(ld_q.size() + done_q.size() + out_q.size()), 64'd0);
   endtask

   task automatic issue(input logic [1:0] op);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = op;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: no finish at cycle %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, r1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_core_run", 64'(core_run), 64'd0);
      chk("rst_core_mode", 64'(core_mode), 64'd0);
      chk("rst_src_addr", 64'(src_addr), 64'd0);
      chk("rst_data_in", 64'(core_data_in), 64'd0);
      chk("rst_done", 64'(core_data_in_done), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_err", 64'(err), 64'd0);

      // LOAD with cmd_valid held: second command only on return to IDLE.
      push_load();
      push_load();
      issue(2'd2);
      wait_run(5, r0);
      @(negedge clk);
      chk("load_busy_ready", 64'(cmd_ready), 64'd0);
      chk("load_mode", 64'(core_mode), 64'd2);
      chk("load_run_pulse", 64'(core_run), 64'd0);
      wait_run(50, r1);
      chk("load_accept_gap", 64'(r1 - r0), 64'd35);
      cmd_valid = 1'b0;
      wait_drain(60);
      @(negedge clk);
      chk("load_idle_ready", 64'(cmd_ready), 64'd1);
      chk("load_idle_mode", 64'(core_mode), 64'd0);

      // NTT: early core_done in run cycle ignored; done at run+500.
      issue(2'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("ntt_run", 64'(core_run), 64'd1);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      chk("ntt_early_done_ignored", 64'(cmd_ready), 64'd0);
      repeat (499) @(negedge clk);
      chk("ntt_waiting", 64'(cmd_ready), 64'd0);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      chk("ntt_ready_after_done", 64'(cmd_ready), 64'd1);
      chk("ntt_err", 64'(err), 64'd0);
      chk("ntt_mode_cleared", 64'(core_mode), 64'd0);

      // INTT timeout, with err_clr coinciding with the timeout cycle.
      issue(2'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("intt_run", 64'(core_run), 64'd1);
      chk("intt_mode", 64'(core_mode), 64'd1);
      repeat (4096) @(negedge clk);
      chk("intt_err_before", 64'(err), 64'd0);
      chk("intt_busy", 64'(cmd_ready), 64'd0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("tmo_set_wins", 64'(err), 64'd1);
      chk("tmo_idle", 64'(cmd_ready), 64'd1);
      @(negedge clk);
      chk("err_sticky", 64'(err), 64'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_cleared", 64'(err), 64'd0);

      // UNLOAD: 32 beats starting DLAT+1 after core_run, no 33rd beat.
      push_unload();
      issue(2'd3);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("unl_run", 64'(core_run), 64'd1);
      wait_drain(60);
      repeat (4) @(negedge clk);
      chk("unl_valid_low", 64'(out_valid), 64'd0);
      chk("unl_idle", 64'(cmd_ready), 64'd1);

      // Reset abort while word 15 is on the load bus.
      issue(2'd2);
      wait_run(5, r0);
      cmd_valid = 1'b0;
      repeat (16) @(negedge clk);
      chk("abort_pre_add", 64'(core_data_in_add), 64'd15);
      chk("abort_pre_data", 64'(core_data_in), 64'd45);
      rst = 1'b1;
      #1;
      chk("abort_data_in", 64'(core_data_in), 64'd0);
      chk("abort_add", 64'(core_data_in_add), 64'd0);
      chk("abort_src_addr", 64'(src_addr), 64'd0);
      chk("abort_mode", 64'(core_mode), 64'd0);
      chk("abort_done", 64'(core_data_in_done), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      push_load();
      issue(2'd2);
      wait_run(5, r0);
      cmd_valid = 1'b0;
      wait_drain(60);
      @(negedge clk);
      chk("reload_idle", 64'(cmd_ready), 64'd1);
      chk("final_err", 64'(err), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/poly_host_seq.md
POLY_HOST_SEQ -- requirements
Module: poly_host_seq

Interface
REQ-001 Parameter: WID, 12, coefficient width; word width = 4*WID = 48.
REQ-002 Parameter: DOUT_LAT, 2, cycles from core_run (UNLOAD) to first valid core_data_out word.
REQ-003 Parameter: TMO, 4096, cycles to wait for core_done before flagging error.
REQ-004 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-005 Ports: rst  in  1  asynchronous, active-high reset.
REQ-006 Ports: cmd_valid  in  1  host command strobe.
REQ-007 Ports: cmd_op  in  2  0=NTT, 1=INTT, 2=LOAD, 3=UNLOAD (equal to core mode codes).
REQ-008 Ports: cmd_ready  out  1  high only in IDLE.
REQ-009 Ports: src_addr  out  5  source memory read address; memory has 1-cycle read latency.
REQ-010 Ports: src_data  in  48  source memory read data.
REQ-011 Ports: core_mode  out  2  mode to poly core.
REQ-012 Ports: core_run  out  1  one-cycle start pulse to poly core.
REQ-013 Ports: core_data_in  out  48  load word to core.
REQ-014 Ports: core_data_in_add  out  5  load word address to core.
REQ-015 Ports: core_data_in_done  out  1  one-cycle end-of-load pulse.
REQ-016 Ports: core_done  in  1  core operation-complete pulse.
REQ-017 Ports: core_data_out  in  48  unload word from core.
REQ-018 Ports: out_valid  out  1  unload word valid; out_data  out  48; out_idx  out  5.
REQ-019 Ports: err  out  1  sticky timeout flag; err_clr  in  1  clears err.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, LOAD_FIN, EXEC, WAIT, UNL_LAT, UNLOAD.
REQ-021 cmd accepted when cmd_valid && cmd_ready; cmd_valid in any other state is ignored (not queued).
REQ-022 On accept: core_mode <= cmd_op and core_run = 1 for exactly the next cycle; core_mode holds until return to IDLE, then 0.
REQ-023 LOAD: src_addr counts 0..31, one per cycle, starting in the core_run cycle.
REQ-024 LOAD: core_data_in = src_data (combinational); core_data_in_add = src_addr delayed one cycle, so words 0..31 present on consecutive cycles 1..32 after core_run.
REQ-025 LOAD_FIN: core_data_in_done = 1 for one cycle, the cycle after word 31; then IDLE.
REQ-026 LOAD total: accept to cmd_ready high again = 35 cycles.
REQ-027 NTT/INTT: EXEC issues core_run, then WAIT until core_done; core_done in the same cycle as core_run ignored.
REQ-028 WAIT: timeout counter; reaching TMO sets err, returns to IDLE.
REQ-029 UNLOAD: after core_run, wait DOUT_LAT cycles (UNL_LAT), then 32 consecutive cycles out_valid = 1, out_data = core_data_out registered, out_idx 0..31.
REQ-030 out_idx wraps 31 -> IDLE; no word 32 produced.
REQ-031 err_clr and timeout same cycle: set wins.
REQ-032 core_done outside WAIT ignored.

Reset
REQ-033 rst SHALL force IDLE immediately, including mid-LOAD/UNLOAD; no done pulse emitted for an aborted operation.
REQ-034 Reset values: cmd_ready 1 after release, all other outputs 0, counters 0, err 0.

Structure
REQ-035 Shared package: mode/op codes (M_NTT, M_INTT, M_DATAIN, M_DATAOUT), POLY_WORDS=32, word width.
REQ-036 One sub-module: poly_seq_cnt (5-bit counter with start/enable/terminal-count), used for load and unload indexing.

Verification
REQ-037 LOAD from ROM with word k = k*3: core_data_in_add 0..31 on cycles 1..32 after core_run, data matching; done pulse cycle 33.
REQ-038 NTT, core_done after 500 cycles: cmd_ready returns the cycle after core_done, err = 0.
REQ-039 INTT, core_done never: err = 1 after 4096 cycles, IDLE; err_clr -> err = 0.
REQ-040 UNLOAD with core_data_out = idx pattern: 32 out_valid beats, out_idx 0..31, first beat DOUT_LAT+1 cycles after core_run.
REQ-041 rst asserted at LOAD word 15: outputs 0 immediately, no data_in_done, next LOAD completes normally.
REQ-042 cmd_valid held high through LOAD: only one command executed, second accepted only on return to IDLE.
